// File: rtl/riscv_defines.sv
// riscv_defines: shared types and defaults for the memory port arbiter
//   arb_state_t         - arbiter FSM states
//   arb_owner_t         - which requester owns the in-flight transaction
//   DEF_MAX_DATA_STREAK - default consecutive data picks allowed while a fetch waits
package riscv_defines;
  localparam int DEF_MAX_DATA_STREAK = 4;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} arb_state_t;
  typedef enum logic {OWNER_FETCH, OWNER_DATA} arb_owner_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters, one transaction in flight
//   clk, rst_n                                      - clock, async active-low reset
//   if_req/if_addr -> if_gnt/if_rvalid/if_rdata     - instruction fetch requester
//   d_req/d_we/d_addr/d_wdata/d_be -> d_gnt/d_rvalid/d_rdata - load/store requester
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be, mem_ready/mem_rvalid/mem_rdata - memory port
module mem_port_arbiter
  import riscv_defines::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int SW = $clog2(MAX_DATA_STREAK + 2);
  arb_state_t            state_q;
  arb_owner_t            owner_q;
  logic [SW-1:0]         streak_q, streak_d;
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   be_q;
  logic                  pick_data, rsp;
  // data wins ties unless the waiting fetch has already been passed over MAX_DATA_STREAK times
  always_comb begin
    pick_data = d_req && !(if_req && streak_q == SW'(MAX_DATA_STREAK));
    streak_d  = (!if_req || !pick_data) ? '0 :
                (streak_q == SW'(MAX_DATA_STREAK)) ? streak_q : streak_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWNER_FETCH;
      streak_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          streak_q <= streak_d;
          if (if_req || d_req) begin
            state_q <= REQ;
            owner_q <= pick_data ? OWNER_DATA : OWNER_FETCH;
            we_q    <= pick_data && d_we;
            addr_q  <= pick_data ? d_addr : if_addr;
            wdata_q <= pick_data ? d_wdata : '0;
            be_q    <= pick_data ? d_be : '1;
          end
        end
        REQ:      if (mem_ready) state_q <= WAIT_RSP;
        WAIT_RSP: if (mem_rvalid) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end
  always_comb begin
    mem_req   = state_q == REQ;
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_be    = be_q;
    if_gnt    = mem_req && mem_ready && owner_q == OWNER_FETCH;
    d_gnt     = mem_req && mem_ready && owner_q == OWNER_DATA;
    // responses only count while waiting; stray mem_rvalid elsewhere is dropped
    rsp       = state_q == WAIT_RSP && mem_rvalid;
    if_rvalid = rsp && owner_q == OWNER_FETCH;
    d_rvalid  = rsp && owner_q == OWNER_DATA;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, corner sequences and randomized model check of mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, MS = 4, NV = 15;
  logic clk = 1'b0, rst_n = 1'b0;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic [DW/8-1:0] d_be = '0;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW/8-1:0] mem_be;
  always #5 clk = ~clk;
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(MS)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  typedef struct packed {
    logic ir, dr, dwe, rdy, rv;
    logic [31:0] rd;
    logic [68:0] e_out;
    logic [68:0] e_fld;
  } vec_t;
  typedef struct packed {
    logic fetch, we;
    logic [31:0] addr, wd;
    logic [3:0] be;
  } txn_t;
  vec_t v [NV];
  int n_cmp = 0, n_err = 0;
  function automatic logic [68:0] outs();
    return {mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid, if_rdata, d_rdata};
  endfunction
  function automatic logic [68:0] flds();
    return {mem_we, mem_addr, mem_wdata, mem_be};
  endfunction
  function automatic vec_t mk(logic ir, logic dr, logic dwe, logic rdy, logic rv, logic [31:0] rd,
                              logic mreq, logic ig, logic dg, logic iv, logic dv, logic [31:0] erd,
                              logic mwe, logic [31:0] maddr, logic [31:0] mwd);
    mk.ir = ir; mk.dr = dr; mk.dwe = dwe; mk.rdy = rdy; mk.rv = rv; mk.rd = rd;
    mk.e_out = {mreq, ig, dg, iv, dv, iv ? erd : 32'h0, dv ? erd : 32'h0};
    mk.e_fld = {mwe, maddr, mwd, 4'hF};
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  string seq;
  int first_g, last_g, cyc;
  txn_t cur;
  bit m_out, m_acc, e_req, e_rv, dw, fp, dp;
  int m_streak;
  initial begin
    //            ir dr we rdy rv rdata        mreq ig dg iv dv erd           mwe addr     wdata
    v[0]  = mk(1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 32'h0,    32'h0);
    v[1]  = mk(1, 0, 0, 1, 0, 32'h0,        1, 1, 0, 0, 0, 32'h0,        0, 32'h100,  32'h0);
    v[2]  = mk(0, 0, 0, 0, 1, 32'h00500093, 0, 0, 0, 1, 0, 32'h00500093, 0, 32'h0,    32'h0);
    v[3]  = mk(0, 0, 0, 0, 1, 32'h55,       0, 0, 0, 0, 0, 32'h0,        0, 32'h0,    32'h0);
    v[4]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 32'h0,    32'h0);
    v[5]  = mk(1, 1, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 32'h0,    32'h0);
    v[6]  = mk(1, 1, 1, 1, 0, 32'h0,        1, 0, 1, 0, 0, 32'h0,        1, 32'h2000, 32'hDEADBEEF);
    v[7]  = mk(1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 32'h0,    32'h0);
    v[8]  = mk(1, 0, 0, 0, 1, 32'h12345678, 0, 0, 0, 0, 1, 32'h12345678, 0, 32'h0,    32'h0);
    v[9]  = mk(1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 32'h0,    32'h0);
    v[10] = mk(1, 0, 0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        0, 32'h100,  32'h0);
    v[11] = mk(1, 0, 0, 0, 1, 32'h77,       1, 0, 0, 0, 0, 32'h0,        0, 32'h100,  32'h0);
    v[12] = mk(1, 0, 0, 1, 1, 32'h77,       1, 1, 0, 0, 0, 32'h0,        0, 32'h100,  32'h0);
    v[13] = mk(0, 0, 0, 0, 1, 32'hA5A5,     0, 0, 0, 1, 0, 32'hA5A5,     0, 32'h0,    32'h0);
    v[14] = mk(0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 32'h0,    32'h0);
    #2;
    chk("reset_outs", outs(), 69'h0);
    chk("reset_fields", flds(), 69'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    if_addr = 32'h100; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
    for (int i = 0; i < NV; i++) begin
      if_req = v[i].ir; d_req = v[i].dr; d_we = v[i].dwe;
      mem_ready = v[i].rdy; mem_rvalid = v[i].rv; mem_rdata = v[i].rd;
      @(negedge clk);
      chk($sformatf("vec%0d_outs", i), outs(), v[i].e_out);
      if (v[i].e_out[68]) chk($sformatf("vec%0d_fields", i), flds(), v[i].e_fld);
      step();
    end
    if_req = 1; d_req = 1; d_we = 0; mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h1;
    seq = ""; first_g = -1; last_g = -1;
    for (cyc = 0; cyc < 60 && seq.len() < 10; cyc++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin
        seq = {seq, d_gnt ? "D" : "F"};
        if (first_g < 0) first_g = cyc;
        last_g = cyc;
      end
      step();
    end
    if (seq.len() < 10) begin
      n_cmp++; n_err++;
      $display("FAIL streak_timeout: got %0d grants expected 10", seq.len());
    end
    n_cmp++;
    if (seq != "DDDDFDDDDF") begin
      n_err++;
      $display("FAIL streak_seq: got %s expected DDDDFDDDDF", seq);
    end
    chk("streak_throughput", 128'(last_g - first_g), 128'd27);
    if_req = 0; d_req = 0;
    repeat (3) step();
    mem_rvalid = 0; mem_ready = 0;
    step();
    d_req = 1; d_we = 0; d_addr = 32'h3000; d_wdata = 32'h11; d_be = 4'h3;
    step();
    d_req = 0; d_addr = 32'hFFFF; d_wdata = 32'h22; d_be = 4'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d", i), {mem_req, if_gnt, d_gnt, flds()}, {3'b100, 1'b0, 32'h3000, 32'h11, 4'h3});
      step();
    end
    mem_ready = 1;
    @(negedge clk);
    chk("stall_gnt", {mem_req, if_gnt, d_gnt, flds()}, {3'b101, 1'b0, 32'h3000, 32'h11, 4'h3});
    step();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE;
    @(negedge clk);
    chk("stall_rsp", outs(), {5'b00001, 32'h0, 32'hCAFE});
    step();
    mem_rvalid = 0; if_req = 1; if_addr = 32'h400;
    step();
    mem_ready = 1;
    step();
    if_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hBAD;
    rst_n = 0;
    #1;
    chk("rst_outs", outs(), 69'h0);
    chk("rst_fields", flds(), 69'h0);
    step();
    rst_n = 1;
    @(negedge clk);
    chk("rst_late_rvalid", outs(), 69'h0);
    step();
    mem_rvalid = 0; if_req = 1; if_addr = 32'h500;
    @(negedge clk);
    chk("post_rst_pick", outs(), 69'h0);
    step();
    mem_ready = 1;
    @(negedge clk);
    chk("post_rst_gnt", {outs(), flds()}, {5'b11000, 64'h0, 1'b0, 32'h500, 32'h0, 4'hF});
    step();
    if_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h99;
    @(negedge clk);
    chk("post_rst_rsp", outs(), {5'b00010, 32'h99, 32'h0});
    step();
    m_out = 0; m_acc = 0; m_streak = 0; fp = 0; dp = 0; cur = '0;
    for (int c = 0; c < 4000; c++) begin
      if (!fp && $urandom_range(1) == 0) begin fp = 1; if_addr = $urandom; end
      if (!dp && $urandom_range(1) == 0) begin
        dp = 1; d_addr = $urandom; d_we = 1'($urandom); d_wdata = $urandom; d_be = 4'($urandom);
      end
      if_req = fp; d_req = dp;
      mem_ready = 1'($urandom); mem_rvalid = $urandom_range(2) == 0; mem_rdata = $urandom;
      @(negedge clk);
      e_req = m_out && !m_acc;
      e_rv = m_out && m_acc && mem_rvalid;
      chk($sformatf("rnd%0d_outs", c), outs(),
          {e_req, e_req && mem_ready && cur.fetch, e_req && mem_ready && !cur.fetch,
           e_rv && cur.fetch, e_rv && !cur.fetch,
           (e_rv && cur.fetch) ? mem_rdata : 32'h0, (e_rv && !cur.fetch) ? mem_rdata : 32'h0});
      if (e_req) chk($sformatf("rnd%0d_fields", c), flds(), {cur.we, cur.addr, cur.wd, cur.be});
      if (if_gnt) fp = 0;
      if (d_gnt) dp = 0;
      if (!m_out) begin
        if (if_req || d_req) begin
          dw = d_req && !(if_req && m_streak == MS);
          cur = dw ? {1'b0, d_we, d_addr, d_wdata, d_be} : {1'b1, 1'b0, if_addr, 32'h0, 4'hF};
          m_streak = (dw && if_req) ? ((m_streak + 1 > MS) ? MS : m_streak + 1) : 0;
          m_out = 1; m_acc = 0;
        end else m_streak = 0;
      end else if (e_req) m_acc = mem_ready;
      else if (e_rv) m_out = 0;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width; MAX_DATA_STREAK, default 4, consecutive data grants allowed while a fetch waits.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  instruction-fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch accepted pulse.
- if_rvalid  out  1  fetch data valid pulse.
- if_rdata  out  DATA_W  fetch data.
- d_req  in  1  load/store request.
- d_we  in  1  1 = store.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  byte enables.
- d_gnt  out  1  data accepted pulse.
- d_rvalid  out  1  load data or store completion pulse.
- d_rdata  out  DATA_W  load data.
- mem_req  out  1  memory request.
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  request fields.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  memory response valid.
- mem_rdata  in  DATA_W  memory response data.

Function
REQ-003 The block SHALL share one memory port between the fetch and data requesters, with at most one transaction outstanding.
REQ-004 FSM states SHALL be IDLE, REQ, and WAIT_RSP.
REQ-005 IDLE: if any request is pending, the block SHALL pick a winner, latch its fields and owner into registers, and go to REQ next cycle.
- A fetch latches mem_we=0, mem_be=all-ones, mem_wdata=0.
REQ-006 Winner selection:
- Data wins when both are pending.
- Exception: fetch wins when streak_cnt == MAX_DATA_STREAK.
REQ-007 streak_cnt behaviour:
- Increments (saturating at MAX_DATA_STREAK) on each data pick made while if_req=1.
- Clears on a fetch pick, or on any IDLE cycle with if_req=0.
REQ-008 REQ: mem_req=1, with fields from the registers and stable until accepted.
- When mem_ready=1, pulse the owner's gnt for that same cycle and go to WAIT_RSP.
REQ-009 WAIT_RSP: mem_req=0.
- When mem_rvalid=1, pulse the owner's rvalid and drive its rdata = mem_rdata combinationally in that cycle, then go to IDLE.
REQ-010 A non-owner's rvalid SHALL stay 0. A non-owner's rdata SHALL be 0.
REQ-011 Minimum latency: request seen in IDLE at cycle N → mem_req at N+1 → gnt at N+1 if mem_ready=1 → rvalid no earlier than N+2. Back-to-back throughput is one transaction per 3 cycles.
REQ-012 Requesters hold req and fields until gnt. A requester dropping req after the IDLE pick SHALL NOT abort the transaction; it completes from the latched fields.
REQ-013 mem_rvalid in IDLE or REQ SHALL be ignored. It produces no rvalid and causes no state change.
REQ-014 mem_rvalid and mem_ready in the same REQ cycle: the response SHALL be ignored; the grant proceeds.
REQ-015 Requests arriving while not in IDLE SHALL wait. No gnt is given outside REQ.

Reset
REQ-016 rst_n low SHALL asynchronously force:
- state = IDLE, streak_cnt = 0, owner = fetch;
- all latched fields = 0;
- every output = 0.
REQ-017 Reset mid-transaction SHALL drop the outstanding access with no rvalid. A late mem_rvalid after release falls under REQ-013.
REQ-018 The first arbitration SHALL occur in the first clock edge with rst_n high.

Structure
REQ-019 The FSM state enum arb_state_t, the owner enum arb_owner_t {OWNER_FETCH, OWNER_DATA}, and the MAX_DATA_STREAK default SHALL live in the shared riscv_defines package.
REQ-020 The block SHALL be a single module with no sub-module. Winner selection SHALL be inline combinational logic feeding the registered FSM.

Verification
REQ-021 Scenarios:
- Fetch only, mem_ready=1, response 1 cycle after gnt, if_addr=0x100, mem_rdata=0x00500093 → mem_req at N+1, if_gnt at N+1, if_rvalid with if_rdata=0x00500093 at N+2, d_* outputs 0 throughout.
- Simultaneous if_req and d_req (store, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=0xF) → data granted first with mem_we=1 and correct fields, d_rvalid on response, then fetch served.
- Both held continuously, MAX_DATA_STREAK=4 → grant sequence D,D,D,D,F,D,D,D,D,F.
- mem_ready held low for 5 cycles in REQ → mem_req and fields stable, no gnt until mem_ready rises.
- Spurious mem_rvalid in IDLE → no rvalid, state stays IDLE. rst_n pulsed low in WAIT_RSP → outputs 0 immediately, no rvalid afterward, next request served normally.
